// File: rtl/can_pkg.sv
// can_pkg: shared CAN receive-path types and constants for the bit destuffer.
package can_pkg;
   typedef enum logic [1:0] {IDLE, COUNT, EXPECT_STUFF, ERROR} destuff_state_e;
   localparam int CAN_STUFF_LEN = 5;
   localparam logic CAN_RECESSIVE = 1'b1;
endpackage

// File: rtl/can_bit_destuff.sv
// can_bit_destuff: removes CAN stuff bits and flags stuff errors ahead of seq_8.
// Optional error counter output err_cnt enabled by CAN_DESTUFF_ERRCNT_EN.
module can_bit_destuff
   import can_pkg::*;
#(
   parameter int STUFF_LEN = CAN_STUFF_LEN,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stuff_en,
   input  logic sample_valid,
   input  logic rx_bit,
   output logic dout,
   output logic dout_valid,
   output logic stuff_drop,
   output logic stuff_err
`ifdef CAN_DESTUFF_ERRCNT_EN
   ,output logic [7:0] err_cnt
`endif
);
   destuff_state_e r_state, w_state_nx;
   logic [CNT_W-1:0] r_run_cnt, w_cnt_nx, w_cnt_base, w_cnt_inc;
   logic r_last_bit, w_last_nx;
   logic w_dout_nx, w_dv_nx, w_drop_nx, w_err_nx;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_run_cnt  <= '0;
         r_last_bit <= CAN_RECESSIVE;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
         stuff_drop <= 1'b0;
         stuff_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_run_cnt  <= w_cnt_nx;
         r_last_bit <= w_last_nx;
         dout       <= w_dout_nx;
         dout_valid <= w_dv_nx;
         stuff_drop <= w_drop_nx;
         stuff_err  <= w_err_nx;
      end
   end
   // Entering from IDLE starts a fresh run, so the first counted bit sees run_cnt=0.
   assign w_cnt_base = (r_state == IDLE) ? '0 : r_run_cnt;
   assign w_cnt_inc  = (w_cnt_base == '0 || rx_bit != r_last_bit) ? CNT_W'(1) : w_cnt_base + 1'b1;
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_run_cnt;
      w_last_nx  = r_last_bit;
      w_dout_nx  = dout;
      w_dv_nx    = 1'b0;
      w_drop_nx  = 1'b0;
      w_err_nx   = stuff_err;
      if (!stuff_en) begin
         w_state_nx = IDLE;
         w_cnt_nx   = '0;
         w_err_nx   = 1'b0;
         w_dout_nx  = sample_valid ? rx_bit : dout;
         w_dv_nx    = sample_valid;
      end else begin
         case (r_state)
            IDLE, COUNT: begin
               w_state_nx = COUNT;
               w_cnt_nx   = w_cnt_base;
               if (sample_valid) begin
                  w_cnt_nx   = w_cnt_inc;
                  w_last_nx  = rx_bit;
                  w_dout_nx  = rx_bit;
                  w_dv_nx    = 1'b1;
                  w_state_nx = (w_cnt_inc == CNT_W'(STUFF_LEN)) ? EXPECT_STUFF : COUNT;
               end
            end
            EXPECT_STUFF: begin
               if (sample_valid) begin
                  w_drop_nx  = rx_bit != r_last_bit;
                  w_err_nx   = rx_bit == r_last_bit;
                  w_cnt_nx   = (rx_bit != r_last_bit) ? CNT_W'(1) : r_run_cnt;
                  w_last_nx  = rx_bit;
                  w_state_nx = (rx_bit != r_last_bit) ? COUNT : ERROR;
               end
            end
            default: ;
         endcase
      end
   end
`ifdef CAN_DESTUFF_ERRCNT_EN
   logic w_err_entry;
   assign w_err_entry = r_state != ERROR && w_state_nx == ERROR;
   always_ff @(posedge clk) begin
      if (!rst_n) err_cnt <= '0;
      else if (w_err_entry && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_can_bit_destuff.sv
// tb_can_bit_destuff: directed plus random stimulus against a window-based stuffing model.
module tb_can_bit_destuff;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stuff_en = 1'b0;
   logic sample_valid = 1'b0;
   logic rx_bit = 1'b0;
   logic dout, dout_valid, stuff_drop, stuff_err;
`ifdef CAN_DESTUFF_ERRCNT_EN
   logic [7:0] err_cnt;
   int e_cnt;
`endif
   can_bit_destuff dut (
      .clk(clk), .rst_n(rst_n), .stuff_en(stuff_en), .sample_valid(sample_valid),
      .rx_bit(rx_bit), .dout(dout), .dout_valid(dout_valid), .stuff_drop(stuff_drop),
      .stuff_err(stuff_err)
`ifdef CAN_DESTUFF_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );
   always #5 clk = ~clk;
   // Model: a bit is a stuff check iff the previous five region bits are identical.
   bit q[$];
   bit in_err;
   logic e_dout, e_v, e_drop, e_err;
   initial begin
      e_dout = 0; e_v = 0; e_drop = 0; e_err = 0; in_err = 0;
`ifdef CAN_DESTUFF_ERRCNT_EN
      e_cnt = 0;
`endif
   end
   function automatic bit window_full();
      if (q.size() < 5) return 0;
      for (int k = 1; k < 5; k++) if (q[q.size()-1-k] != q[q.size()-1]) return 0;
      return 1;
   endfunction
   always @(posedge clk) begin
      e_v = 0;
      e_drop = 0;
      if (!rst_n) begin
         q.delete(); in_err = 0; e_dout = 0; e_err = 0;
`ifdef CAN_DESTUFF_ERRCNT_EN
         e_cnt = 0;
`endif
      end else if (!stuff_en) begin
         q.delete(); in_err = 0; e_err = 0;
         if (sample_valid) begin e_dout = rx_bit; e_v = 1; end
      end else if (sample_valid && !in_err) begin
         if (window_full()) begin
            if (rx_bit != q[q.size()-1]) begin e_drop = 1; q.push_back(rx_bit); end
            else begin
               in_err = 1; e_err = 1;
`ifdef CAN_DESTUFF_ERRCNT_EN
               if (e_cnt < 255) e_cnt++;
`endif
            end
         end else begin
            e_dout = rx_bit; e_v = 1; q.push_back(rx_bit);
         end
         if (q.size() > 8) void'(q.pop_front());
      end
   end
   int n_tests = 0, n_fail = 0;
   logic [31:0] cap = 0;
   int ncap = 0, ndrop = 0;
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, a, e, $time);
      end
   endtask
   task automatic cmp();
      chk("dout_valid", 32'(dout_valid), 32'(e_v));
      chk("stuff_drop", 32'(stuff_drop), 32'(e_drop));
      chk("stuff_err", 32'(stuff_err), 32'(e_err));
      if (e_v) chk("dout", 32'(dout), 32'(e_dout));
      if (dout_valid && stuff_drop) chk("strobe_excl", 32'(1), 32'(0));
`ifdef CAN_DESTUFF_ERRCNT_EN
      chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
`endif
      if (dout_valid) begin cap = {cap[30:0], dout}; ncap++; end
      if (stuff_drop) ndrop++;
   endtask
   task automatic tick(input logic sv, input logic b, input logic en);
      @(negedge clk);
      cmp();
      sample_valid = sv; rx_bit = b; stuff_en = en;
   endtask
   task automatic bits(input logic [31:0] v, input int n, input logic en);
      for (int i = n - 1; i >= 0; i--) begin
         tick(1'b1, v[i], en);
         tick(1'b0, 1'b0, en);
      end
   endtask
   int c0, d0;
   logic prev;
   initial begin
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      chk("rst_dout", 32'(dout), 32'(0));
      chk("rst_err", 32'(stuff_err), 32'(0));
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      c0 = ncap; d0 = ndrop;
      bits(32'h7F, 7, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("pass_n", 32'(ncap - c0), 32'd7);
      chk("pass_val", cap & 32'h7F, 32'h7F);
      chk("pass_drop", 32'(ndrop - d0), 32'd0);
      c0 = ncap; d0 = ndrop;
      bits(32'b00000101, 8, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      chk("stuff_n", 32'(ncap - c0), 32'd7);
      chk("stuff_val", cap & 32'h7F, 32'b0000001);
      chk("stuff_drop_n", 32'(ndrop - d0), 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      c0 = ncap; d0 = ndrop;
      bits(32'b11111000001, 11, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      chk("chain_n", 32'(ncap - c0), 32'd9);
      chk("chain_val", cap & 32'h1FF, 32'b111110000);
      chk("chain_drop_n", 32'(ndrop - d0), 32'd2);
      tick(1'b0, 1'b0, 1'b0);
      c0 = ncap;
      bits(32'b000000000, 9, 1'b1);
      chk("err_n", 32'(ncap - c0), 32'd5);
      chk("err_flag", 32'(stuff_err), 32'd1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("err_clear", 32'(stuff_err), 32'd0);
`ifdef CAN_DESTUFF_ERRCNT_EN
      chk("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
      c0 = ncap; d0 = ndrop;
      bits(32'b00000, 5, 1'b1);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("bound_n", 32'(ncap - c0), 32'd6);
      chk("bound_err", 32'(stuff_err), 32'd0);
      chk("bound_drop", 32'(ndrop - d0), 32'd0);
      prev = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) prev = ~prev;
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            tick(1'b1, prev, 1'b1);
            rst_n = 1'b1;
         end else begin
            tick(1'($urandom_range(0, 9) < 7), prev,
                 ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
         end
      end
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
Receive-path stage that sits directly upstream of the 8-bit sequence detector (seq_8). It takes the sampled CAN bit stream, removes stuff bits inside the stuffing region, and presents the destuffed stream to the detector's din. It also flags stuff errors: more than STUFF_LEN consecutive identical bits.

Parameters:
STUFF_LEN, 5, number of consecutive identical bits after which the next bit is a stuff bit
CNT_W, 3, width of the run-length counter; must hold STUFF_LEN

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
stuff_en  input  1  high inside the stuffed region (SOF..CRC); low means pass-through
sample_valid  input  1  one-cycle strobe, one per received CAN bit
rx_bit  input  1  sampled bus bit, qualified by sample_valid
dout  output  1  destuffed bit; feeds seq_8 din
dout_valid  output  1  one-cycle strobe, dout is a data bit
stuff_drop  output  1  one-cycle strobe, current bit was a correct stuff bit and was removed
stuff_err  output  1  sticky stuff-error flag

Behaviour:
- Reset (rst_n=0 at a clk edge): dout=0, dout_valid=0, stuff_drop=0, stuff_err=0, run_cnt=0, last_bit=1 (recessive), state=IDLE.
- All outputs are registered. Latency is 1 clk from the sample_valid edge to dout_valid or stuff_drop. dout_valid and stuff_drop are never high together.
- Cycles with sample_valid=0 change no state. Strobes deassert the following cycle.
- States:
  - IDLE: stuff_en=0. Each valid bit passes through: dout=rx_bit, dout_valid=1, no counting. stuff_en=1 moves to COUNT with run_cnt=0.
  - COUNT: on a valid bit, if run_cnt==0 or rx_bit!=last_bit, then run_cnt=1; else run_cnt+=1. Bit is output: dout_valid=1, last_bit=rx_bit. If run_cnt reaches STUFF_LEN, go to EXPECT_STUFF.
  - EXPECT_STUFF: on a valid bit:
    - rx_bit!=last_bit: stuff_drop=1, dout_valid=0, run_cnt=1, last_bit=rx_bit, go to COUNT. The stuff bit counts toward the next run.
    - rx_bit==last_bit: stuff_err=1, dout_valid=0, go to ERROR.
  - ERROR: no outputs produced; valid bits are ignored. Leave only when stuff_en=0, going to IDLE. stuff_err clears on that same transition.
- stuff_en falling in any state: go to IDLE next cycle. If sample_valid is high in that same cycle, the bit is handled as IDLE pass-through (stuff_en wins).
- stuff_en rising together with sample_valid: that bit is the first counted bit (run_cnt=1).
- Stuff bit following a run that ends exactly when stuff_en falls: not checked; IDLE passes it through.
- run_cnt never exceeds STUFF_LEN; there is no wrap.
- Reset mid-frame: all state returns to reset values on the next edge. Any pending stuff expectation is discarded.

Optional Feature:
Macro: CAN_DESTUFF_ERRCNT_EN
- Defined: adds output err_cnt [7:0]. It increments (saturating at 255) on each transition into ERROR, clears only on reset, and is 0 at reset.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package can_pkg: state enum for the destuffer (IDLE, COUNT, EXPECT_STUFF, ERROR), localparam CAN_STUFF_LEN=5, and the recessive-level constant CAN_RECESSIVE=1'b1.
- No sub-module is needed; the FSM and run counter live in one module. The error counter is an inline generate/ifdef block.

Test Plan:
- Reset: hold rst_n=0 for 2 clk with sample_valid toggling -> all outputs 0, no strobes. Release -> IDLE.
- Pass-through: stuff_en=0, bits 1,1,1,1,1,1,1 -> 7 dout_valid strobes, dout=1 each, stuff_drop never high, stuff_err=0.
- Correct stuff: stuff_en=1, bits 0,0,0,0,0,1,0,1 -> dout_valid on bits 1-5 (dout=0) and on bits 7-8. Bit 6 gives stuff_drop=1 one clk after its strobe. After bit 6, run_cnt=1.
- Chained stuff: stuff_en=1, bits 1×5, 0, 0×4, 1 -> both stuff bits (positions 6 and 11) dropped. The stuff 0 counts toward the run of five 0s. Output stream is 1×5, 0×4.
- Stuff error: stuff_en=1, bits 0×6 -> bits 1-5 valid; bit 6 sets stuff_err=1 with no dout_valid; later bits give no output. Drop stuff_en -> stuff_err=0 next clk, IDLE. With CAN_DESTUFF_ERRCNT_EN, err_cnt=1.
- Boundary: stuff_en falls in the same cycle as the sample_valid of a 6th identical bit -> bit passes through with dout_valid=1, no stuff_err.
